// File: rtl/edge_detector_bank.sv
// edge_detector_bank: multi-channel synchroniser, optional debounce, mode-gated edge pulses and sticky pending flags.
// Define EDGE_BANK_DEBOUNCE_EN to build the per-channel debounce counters.
module edge_detector_bank #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [CHANNELS-1:0]     signal_i,
    input  logic [2*CHANNELS-1:0]   mode_i,
    input  logic [CHANNELS-1:0]     clear_i,
    output logic [CHANNELS-1:0]     level_o,
    output logic [CHANNELS-1:0]     rising_o,
    output logic [CHANNELS-1:0]     falling_o,
    output logic [CHANNELS-1:0]     event_o,
    output logic [CHANNELS-1:0]     pending_o,
    output logic                    any_pending_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("edge_detector_bank: invalid parameters");
    end

    logic [SYNC_STAGES*CHANNELS-1:0] chain_q;
    logic [CHANNELS-1:0] sync, level_q, rising_q, falling_q, pending_q;
    logic [CHANNELS-1:0] accept, rise_d, fall_d, mode_rise, mode_fall;

    assign sync = chain_q[SYNC_STAGES*CHANNELS-1 -: CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign mode_rise[c] = mode_i[2*c];
        assign mode_fall[c] = mode_i[2*c+1];
`ifdef EDGE_BANK_DEBOUNCE_EN
        logic [CW-1:0] cnt_q;
        always_ff @(posedge clock_i) begin
            if (reset_i || !enable_i || sync[c] == level_q[c] || accept[c])
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);
        end
        assign accept[c] = enable_i && sync[c] != level_q[c] && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
`else
        assign accept[c] = enable_i && sync[c] != level_q[c];
`endif
    end

    assign rise_d = accept & sync & mode_rise;
    assign fall_d = accept & ~sync & mode_fall;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            chain_q   <= '0;
            level_q   <= '0;
            rising_q  <= '0;
            falling_q <= '0;
            pending_q <= '0;
        end else begin
            chain_q   <= {chain_q[(SYNC_STAGES-1)*CHANNELS-1:0], signal_i};
            level_q   <= enable_i ? level_q ^ accept : sync;
            rising_q  <= rise_d;
            falling_q <= fall_d;
            // an event still showing on event_o also outlasts a same-cycle clear
            pending_q <= (pending_q & ~clear_i) | rise_d | fall_d | rising_q | falling_q;
        end
    end

    assign level_o       = level_q;
    assign rising_o      = rising_q;
    assign falling_o     = falling_q;
    assign event_o       = rising_q | falling_q;
    assign pending_o     = pending_q;
    assign any_pending_o = |pending_q;
endmodule

// File: tb/tb_edge_detector_bank.sv
// tb_edge_detector_bank: directed checks of accept latency, glitch rejection, mode gating, pending clear, enable and reset.
module tb_edge_detector_bank;
    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int DEB = 4;
`ifdef EDGE_BANK_DEBOUNCE_EN
    localparam bit DB  = 1'b1;
    localparam int LAT = SS + DEB;
`else
    localparam bit DB  = 1'b0;
    localparam int LAT = SS + 1;
`endif

    logic            clock_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            enable_i = 1'b0;
    logic [CH-1:0]   signal_i = '0;
    logic [2*CH-1:0] mode_i = '0;
    logic [CH-1:0]   clear_i = '0;
    logic [CH-1:0]   level_o, rising_o, falling_o, event_o, pending_o;
    logic            any_pending_o;

    int total = 0;
    int passed = 0;

    edge_detector_bank #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .signal_i(signal_i),
        .mode_i(mode_i), .clear_i(clear_i), .level_o(level_o), .rising_o(rising_o),
        .falling_o(falling_o), .event_o(event_o), .pending_o(pending_o),
        .any_pending_o(any_pending_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic run_ticks(input int n, input int c, output int r, output int f);
        r = 0;
        f = 0;
        repeat (n) begin
            tick();
            r += int'(rising_o[c]);
            f += int'(falling_o[c]);
        end
    endtask

    task automatic mode_run(input logic [1:0] m, input int exp_r, input int exp_f, input string tag);
        int r1, f1, r2, f2;
        mode_i[5:4] = m;
        signal_i[2] = 1'b1;
        run_ticks(10, 2, r1, f1);
        chk({tag, "_level_hi"}, 32'(level_o[2]), 32'd1);
        signal_i[2] = 1'b0;
        run_ticks(10, 2, r2, f2);
        chk({tag, "_level_lo"}, 32'(level_o[2]), 32'd0);
        chk({tag, "_rises"}, 32'(r1 + r2), 32'(exp_r));
        chk({tag, "_falls"}, 32'(f1 + f2), 32'(exp_f));
    endtask

    initial begin
        int r, f;
        repeat (2) tick();
        chk("reset_outputs", {11'd0, level_o, rising_o, falling_o, event_o, pending_o, any_pending_o}, 32'd0);
        reset_i  = 1'b0;
        enable_i = 1'b1;
        mode_i   = 8'b00_00_00_01;
        tick();

        // rising accept on ch0
        signal_i[0] = 1'b1;
        repeat (LAT - 1) tick();
        chk("t1_no_early_rise", 32'(rising_o[0]), 32'd0);
        chk("t1_no_early_level", 32'(level_o[0]), 32'd0);
        tick();
        chk("t1_rise", 32'(rising_o[0]), 32'd1);
        chk("t1_event", 32'(event_o[0]), 32'd1);
        chk("t1_level", 32'(level_o[0]), 32'd1);
        chk("t1_pending", 32'(pending_o[0]), 32'd1);
        chk("t1_no_fall", 32'(falling_o), 32'd0);
        tick();
        chk("t1_one_cycle", 32'(rising_o[0]), 32'd0);
        chk("t1_pending_held", 32'(pending_o[0]), 32'd1);

        // 3-cycle glitch on ch1
        mode_i[3:2] = 2'b11;
        signal_i[1] = 1'b1;
        run_ticks(3, 1, r, f);
        begin
            int r2, f2;
            signal_i[1] = 1'b0;
            run_ticks(12, 1, r2, f2);
            r += r2;
            f += f2;
        end
        chk("t2_rises", 32'(r), DB ? 32'd0 : 32'd1);
        chk("t2_falls", 32'(f), DB ? 32'd0 : 32'd1);
        chk("t2_level", 32'(level_o[1]), 32'd0);

        // mode gating on ch2
        mode_run(2'b10, 0, 1, "t3_m10");
        mode_run(2'b11, 1, 1, "t3_m11");
        mode_run(2'b00, 0, 0, "t3_m00");

        // pending clear
        clear_i = 4'hF;
        tick();
        clear_i = 4'h0;
        chk("t4_cleared_all", 32'(pending_o), 32'd0);
        chk("t4_any_cleared", 32'(any_pending_o), 32'd0);
        mode_i[1:0] = 2'b11;
        signal_i[0] = 1'b0;
        repeat (LAT - 1) tick();
        clear_i[0] = 1'b1;
        tick();
        chk("t4_fall", 32'(falling_o[0]), 32'd1);
        chk("t4_set_wins", 32'(pending_o[0]), 32'd1);
        tick();
        chk("t4_clear_with_event", 32'(pending_o[0]), 32'd1);
        tick();
        chk("t4_clear_alone", 32'(pending_o[0]), 32'd0);
        chk("t4_any_after_clear", 32'(any_pending_o), 32'd0);
        clear_i = 4'h0;

        // enable gating on ch3
        mode_i[7:6] = 2'b11;
        enable_i = 1'b0;
        signal_i[3] = 1'b1;
        run_ticks(5, 3, r, f);
        chk("t5_level_disabled", 32'(level_o[3]), 32'd1);
        enable_i = 1'b1;
        begin
            int r2, f2;
            run_ticks(LAT + 2, 3, r2, f2);
            r += r2 + f + f2;
        end
        chk("t5_no_pulse", 32'(r), 32'd0);
        chk("t5_level_enabled", 32'(level_o[3]), 32'd1);

        // reset mid-count on ch0
        mode_i[1:0] = 2'b01;
        signal_i[0] = 1'b1;
        repeat (4) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("t6_reset_outputs", {11'd0, level_o, rising_o, falling_o, event_o, pending_o, any_pending_o}, 32'd0);
        repeat (LAT - 1) tick();
        chk("t6_no_early_rise", 32'(rising_o[0]), 32'd0);
        tick();
        chk("t6_rise_after_reset", 32'(rising_o[0]), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
